// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: start/data/parity/stop sampling, external parity
// checker handshake and a single per-frame status pulse.
module uart_rx_frame_ctrl #(
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_serial,
    input  logic              parity_err_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_bit,
    output logic              parity_load,
    output logic              rx_valid,
    output logic              rx_parity_error,
    output logic              rx_frame_error,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CHECK
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_parity_bit_q, rx_parity_bit_d;
    logic                stop_ok_q, stop_ok_d;
    logic                rxs, cnt_wrap;

    assign rxs      = sync2_q;
    assign cnt_wrap = (cnt_q == CNT_LAST);

    always_comb begin
        state_d         = state_q;
        sync1_d         = rx_serial;
        sync2_d         = sync1_q;
        cnt_d           = cnt_wrap ? '0 : cnt_q + CW'(1);
        bit_idx_d       = bit_idx_q;
        rx_data_d       = rx_data_q;
        rx_parity_bit_d = rx_parity_bit_q;
        stop_ok_d       = stop_ok_q;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                // Mid start bit: a high line here means the edge was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_wrap) begin
                    rx_data_d[bit_idx_q] = rxs;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = S_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (cnt_wrap) begin
                    rx_parity_bit_d = rxs;
                    state_d         = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_wrap) begin
                    stop_ok_d = rxs;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            rx_data_q       <= '0;
            rx_parity_bit_q <= 1'b0;
            stop_ok_q       <= 1'b1;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            rx_data_q       <= rx_data_d;
            rx_parity_bit_q <= rx_parity_bit_d;
            stop_ok_q       <= stop_ok_d;
        end
    end

    // Status is only meaningful in CHECK, where the checker answers combinationally.
    always_comb begin
        parity_load     = (state_q == S_CHECK);
        rx_valid        = (state_q == S_CHECK);
        rx_parity_error = (state_q == S_CHECK) & parity_err_in;
        rx_frame_error  = (state_q == S_CHECK) & ~stop_ok_q;
        busy            = (state_q != S_IDLE);
    end

    assign rx_data       = rx_data_q;
    assign rx_parity_bit = rx_parity_bit_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a behavioural even-parity checker.
module tb_uart_rx_frame_ctrl;
    localparam int DW = 32;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_serial;
    logic          parity_err_in;
    logic [DW-1:0] rx_data;
    logic          rx_parity_bit, parity_load, rx_valid;
    logic          rx_parity_error, rx_frame_error, busy;

    uart_rx_frame_ctrl #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rx_serial(rx_serial), .parity_err_in(parity_err_in),
        .rx_data(rx_data), .rx_parity_bit(rx_parity_bit), .parity_load(parity_load),
        .rx_valid(rx_valid), .rx_parity_error(rx_parity_error),
        .rx_frame_error(rx_frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // External checker: even parity, answers only while loaded.
    assign parity_err_in = parity_load & (rx_parity_bit != ^rx_data);

    int n_chk = 0, n_err = 0;
    int nv = 0, cyc = 0, pl_bad = 0, err_bad = 0;
    logic [DW-1:0] v_data [32];
    logic          v_perr [32];
    logic          v_ferr [32];
    logic          v_pl   [32];
    int            v_t    [32];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (parity_load !== rx_valid) pl_bad++;
        if (!rx_valid && (rx_parity_error || rx_frame_error)) err_bad++;
        if (rx_valid === 1'b1) begin
            v_data[nv % 32] = rx_data;
            v_perr[nv % 32] = rx_parity_error;
            v_ferr[nv % 32] = rx_frame_error;
            v_pl[nv % 32]   = parity_load;
            v_t[nv % 32]    = cyc;
            nv++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_serial = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic wait_valid(input string tag, input int target);
        int k = 0;
        while (nv < target && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(nv), 64'(target));
    endtask

    task automatic frame_case(input string tag, input logic [DW-1:0] d, input logic p,
                              input logic s, input logic exp_perr, input logic exp_ferr);
        int n0 = nv;
        send_frame(d, p, s);
        rx_serial = 1'b1;
        wait_valid({tag, "_cnt"}, n0 + 1);
        chk({tag, "_data"}, 64'(v_data[n0 % 32]), 64'(d));
        chk({tag, "_perr"}, 64'(v_perr[n0 % 32]), 64'(exp_perr));
        chk({tag, "_ferr"}, 64'(v_ferr[n0 % 32]), 64'(exp_ferr));
        chk({tag, "_pload"}, 64'(v_pl[n0 % 32]), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_once"}, 64'(nv), 64'(n0 + 1));
    endtask

    initial begin
        int n0, k;
        rst = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(rx_data), 64'd0);
        chk("rst_pbit", 64'(rx_parity_bit), 64'd0);
        chk("rst_flags", {60'd0, rx_valid, parity_load, rx_parity_error, rx_frame_error}, 64'd0);
        repeat (4) @(negedge clk);

        frame_case("f_a5a5", 32'hA5A5_0F0F, 1'b0, 1'b1, 1'b0, 1'b0);
        frame_case("f_0001", 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        frame_case("f_ffff", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // One-cycle low glitch on an idle line
        n0 = nv;
        rx_serial = 1'b0;
        @(negedge clk);
        rx_serial = 1'b1;
        k = 0;
        while (!busy && k < 6) begin @(negedge clk); k++; end
        chk("glitch_busy_rise", 64'(busy), 64'd1);
        k = 0;
        while (busy && k < 20) begin @(negedge clk); k++; end
        chk("glitch_busy_fall", 64'(k <= C / 2 + 3), 64'd1);
        repeat (3 * C) @(negedge clk);
        chk("glitch_no_valid", 64'(nv), 64'(n0));

        // Reset during data bit 10, then a clean frame
        n0 = nv;
        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        rx_serial = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_serial = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_data", 64'(rx_data), 64'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_valid", 64'(nv), 64'(n0));
        frame_case("f_1234", 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Back-to-back frames: pulses are one on-wire frame length apart
        n0 = nv;
        send_frame(32'hDEAD_BEEF, 1'b0, 1'b1);
        send_frame(32'h0000_0000, 1'b0, 1'b1);
        rx_serial = 1'b1;
        wait_valid("b2b_cnt", n0 + 2);
        chk("b2b_data0", 64'(v_data[n0 % 32]), 64'hDEAD_BEEF);
        chk("b2b_data1", 64'(v_data[(n0 + 1) % 32]), 64'h0);
        chk("b2b_err0", {62'd0, v_perr[n0 % 32], v_ferr[n0 % 32]}, 64'd0);
        chk("b2b_err1", {62'd0, v_perr[(n0 + 1) % 32], v_ferr[(n0 + 1) % 32]}, 64'd0);
        chk("b2b_gap", 64'(v_t[(n0 + 1) % 32] - v_t[n0 % 32]), 64'((DW + 3) * C));
        repeat (4) @(negedge clk);

        // Break: line held low gives repeated framing errors
        n0 = nv;
        rx_serial = 1'b0;
        repeat (300) @(negedge clk);
        chk("brk_cnt", 64'(nv >= n0 + 2), 64'd1);
        chk("brk_ferr0", 64'(v_ferr[n0 % 32]), 64'd1);
        chk("brk_ferr1", 64'(v_ferr[(n0 + 1) % 32]), 64'd1);
        chk("brk_data0", 64'(v_data[n0 % 32]), 64'd0);
        rx_serial = 1'b1;
        repeat (200) @(negedge clk);
        chk("brk_idle", 64'(busy), 64'd0);

        chk("pload_eq_valid", 64'(pl_bad), 64'd0);
        chk("flags_unqualified", 64'(err_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
